// File: rtl/glyph_fetch_sched.sv
// glyph_fetch_sched: during horizontal blanking, fetches the three digit glyph
// rows for the next scan line from the shared glyph memory into shadow
// registers, then publishes them atomically to the pixel-path line buffers.
module glyph_fetch_sched #(
  parameter int H_VIZ      = 640,
  parameter int V_TOP      = 200,
  parameter int GLYPH_ROWS = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic        clk_fs,
  input  logic        rst_fs,
  input  logic [9:0]  h_index,
  input  logic [9:0]  v_index,
  input  logic [31:0] line_data,
  output logic [1:0]  digit_sel,
  output logic        en_mem,
  output logic [4:0]  line_sel,
  output logic [31:0] buf_sec,
  output logic [31:0] buf_dec,
  output logic [31:0] buf_min,
  output logic        buf_valid,
  output logic        ovr_err
);

  localparam logic [9:0] L_HVIZ = 10'(H_VIZ);
  localparam logic [9:0] L_TOP  = 10'(V_TOP);
  localparam logic [9:0] L_END  = 10'(V_TOP + GLYPH_ROWS);
  // WAIT lasts MEM_LAT-1 cycles; counter is loaded with one less than that
  localparam logic [1:0] L_WAIT = 2'(MEM_LAT - 2);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CAP, S_PUB} state_t;

  state_t      r_state;
  logic [1:0]  r_k;
  logic [1:0]  r_wait_cnt;
  logic [31:0] r_sh_sec, r_sh_dec, r_sh_min;
  logic [1:0]  r_digit_sel;
  logic        r_en_mem;
  logic [4:0]  r_line_sel;
  logic [31:0] r_buf_sec, r_buf_dec, r_buf_min;
  logic        r_buf_valid;
  logic        r_ovr_err;

  logic [9:0]  w_target;
  logic        w_tgt_band;
  logic        w_cur_band;
  logic [4:0]  w_row;
  logic        w_trigger;
  logic        w_hstart;

  // Next-line target row and band membership tests
  always_comb begin
    w_target   = v_index + 10'd1;
    w_tgt_band = (w_target >= L_TOP) && (w_target < L_END);
    w_cur_band = (v_index >= L_TOP) && (v_index < L_END);
    w_row      = 5'(w_target - L_TOP);
    w_trigger  = (h_index == L_HVIZ) && w_tgt_band;
    w_hstart   = (h_index == 10'd0);
  end

  // Fetch sequencer: IDLE -> (REQ -> [WAIT] -> CAP) x3 -> PUB, with overrun abort
  always_ff @(posedge clk_fs) begin
    if (rst_fs) begin
      r_state     <= S_IDLE;
      r_k         <= 2'd0;
      r_wait_cnt  <= 2'd0;
      r_sh_sec    <= '0;
      r_sh_dec    <= '0;
      r_sh_min    <= '0;
      r_digit_sel <= 2'd0;
      r_en_mem    <= 1'b0;
      r_line_sel  <= 5'd0;
      r_buf_sec   <= '0;
      r_buf_dec   <= '0;
      r_buf_min   <= '0;
      r_buf_valid <= 1'b0;
      r_ovr_err   <= 1'b0;
    end else begin
      r_en_mem <= 1'b0;
      if (w_hstart && r_state != S_IDLE) begin
        // Line wrapped before the fetch finished: drop it, keep old buffers
        r_state     <= S_IDLE;
        r_ovr_err   <= 1'b1;
        r_buf_valid <= 1'b0;
      end else begin
        if (w_hstart && !w_cur_band) r_buf_valid <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_trigger) begin
              r_line_sel  <= w_row;
              r_k         <= 2'd0;
              r_digit_sel <= 2'd0;
              r_en_mem    <= 1'b1;
              r_state     <= S_REQ;
            end
          end
          S_REQ: begin
            if (MEM_LAT > 1) begin
              r_wait_cnt <= L_WAIT;
              r_state    <= S_WAIT;
            end else begin
              r_state <= S_CAP;
            end
          end
          S_WAIT: begin
            if (r_wait_cnt == 2'd0) r_state <= S_CAP;
            else                    r_wait_cnt <= r_wait_cnt - 2'd1;
          end
          S_CAP: begin
            case (r_k)
              2'd0:    r_sh_sec <= line_data;
              2'd1:    r_sh_dec <= line_data;
              default: r_sh_min <= line_data;
            endcase
            if (r_k == 2'd2) begin
              r_state <= S_PUB;
            end else begin
              r_k         <= r_k + 2'd1;
              r_digit_sel <= r_k + 2'd1;
              r_en_mem    <= 1'b1;
              r_state     <= S_REQ;
            end
          end
          S_PUB: begin
            r_buf_sec   <= r_sh_sec;
            r_buf_dec   <= r_sh_dec;
            r_buf_min   <= r_sh_min;
            r_buf_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign digit_sel = r_digit_sel;
  assign en_mem    = r_en_mem;
  assign line_sel  = r_line_sel;
  assign buf_sec   = r_buf_sec;
  assign buf_dec   = r_buf_dec;
  assign buf_min   = r_buf_min;
  assign buf_valid = r_buf_valid;
  assign ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_glyph_fetch_sched.sv
// Bench for glyph_fetch_sched: one instance at MEM_LAT=1 and one at MEM_LAT=3
// share the scan counters; each has its own latency-matched memory model.
module tb_glyph_fetch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_index, v_index;
  logic [31:0] ld   [2];
  logic [1:0]  ds   [2];
  logic        em   [2];
  logic [4:0]  ls   [2];
  logic [31:0] bs   [2], bd [2], bm [2];
  logic        bv   [2], oe [2];

  int lat [2] = '{1, 3};
  int n_chk = 0, n_pass = 0;

  logic [31:0] exp_buf [2][3];
  bit          exp_valid [2], exp_ovr [2], pending [2];
  logic [15:0] salt;

  always #20 clk = ~clk;

  glyph_fetch_sched #(.MEM_LAT(1)) u_l1 (
    .clk_fs(clk), .rst_fs(rst), .h_index(h_index), .v_index(v_index),
    .line_data(ld[0]), .digit_sel(ds[0]), .en_mem(em[0]), .line_sel(ls[0]),
    .buf_sec(bs[0]), .buf_dec(bd[0]), .buf_min(bm[0]),
    .buf_valid(bv[0]), .ovr_err(oe[0]));

  glyph_fetch_sched #(.MEM_LAT(3)) u_l3 (
    .clk_fs(clk), .rst_fs(rst), .h_index(h_index), .v_index(v_index),
    .line_data(ld[1]), .digit_sel(ds[1]), .en_mem(em[1]), .line_sel(ls[1]),
    .buf_sec(bs[1]), .buf_dec(bd[1]), .buf_min(bm[1]),
    .buf_valid(bv[1]), .ovr_err(oe[1]));

  // Glyph content encodes digit, row and a per-line salt
  function automatic logic [31:0] mdata(input logic [1:0] s, input logic [4:0] row,
                                        input logic [15:0] slt);
    return {slt, 3'b0, row, 6'b0, s};
  endfunction

  function automatic bit inband(input int t);
    return (t >= 200) && (t < 232);
  endfunction

  // Memory models: data valid MEM_LAT cycles after the strobe, garbage otherwise
  logic [31:0] p1, p3 [3];
  always @(posedge clk) begin
    p1    <= em[0] ? mdata(ds[0], ls[0], salt) : 32'hDEAD_BEEF;
    p3[0] <= em[1] ? mdata(ds[1], ls[1], salt) : 32'hDEAD_BEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ld[0] = p1;
  assign ld[1] = p3[2];

  task automatic tick(input int hh);
    h_index = 10'(hh);
    @(posedge clk);
    #1;
  endtask

  // One scan line: drives a compressed h sequence and checks every edge
  task automatic run_line(input int vv, input bit abort_early);
    int hs[$];
    bit trig;
    logic [4:0] row;
    int last_h;
    hs = '{0, 1, 2, 3};
    for (int x = 636; x <= (abort_early ? 641 : 660); x++) hs.push_back(x);
    if (!abort_early) begin
      hs.push_back(797); hs.push_back(798); hs.push_back(799);
    end
    v_index = 10'(vv);
    trig = inband(vv + 1);
    row  = 5'(vv - 199);
    foreach (hs[j]) begin
      int hh;
      hh = hs[j];
      tick(hh);
      for (int i = 0; i < 2; i++) begin
        int f, d;
        bit act, e_en;
        f = 3 * (1 + lat[i]);
        d = hh - 640;
        if (hh == 0) begin
          if (pending[i]) begin
            exp_ovr[i] = 1'b1; exp_valid[i] = 1'b0; pending[i] = 1'b0;
          end else if (!inband(vv)) begin
            exp_valid[i] = 1'b0;
          end
        end
        act = trig && d >= 0 && d < f;
        if (trig && d == f + 1) begin
          for (int k = 0; k < 3; k++) exp_buf[i][k] = mdata(2'(k), row, salt);
          exp_valid[i] = 1'b1;
        end
        e_en = act && (d % (1 + lat[i]) == 0);
        n_chk++;
        if (em[i] !== e_en)
          $display("FAIL en_mem lat%0d v=%0d h=%0d got %0b want %0b", lat[i], vv, hh, em[i], e_en);
        else n_pass++;
        n_chk++;
        if (ds[i] === 2'd3 || $isunknown(ds[i]))
          $display("FAIL digit_sel_range lat%0d v=%0d h=%0d got %0d want 0..2", lat[i], vv, hh, ds[i]);
        else n_pass++;
        if (act) begin
          n_chk++;
          if (ds[i] !== 2'(d / (1 + lat[i])))
            $display("FAIL digit_sel lat%0d v=%0d h=%0d got %0d want %0d", lat[i], vv, hh, ds[i], d / (1 + lat[i]));
          else n_pass++;
        end
        if (trig && d >= 0) begin
          n_chk++;
          if (ls[i] !== row)
            $display("FAIL line_sel lat%0d v=%0d h=%0d got %0d want %0d", lat[i], vv, hh, ls[i], row);
          else n_pass++;
        end
        n_chk++;
        if (bv[i] !== exp_valid[i])
          $display("FAIL buf_valid lat%0d v=%0d h=%0d got %0b want %0b", lat[i], vv, hh, bv[i], exp_valid[i]);
        else n_pass++;
        n_chk++;
        if ({bm[i], bd[i], bs[i]} !== {exp_buf[i][2], exp_buf[i][1], exp_buf[i][0]})
          $display("FAIL buffers lat%0d v=%0d h=%0d got %h %h %h want %h %h %h", lat[i], vv, hh,
                   bs[i], bd[i], bm[i], exp_buf[i][0], exp_buf[i][1], exp_buf[i][2]);
        else n_pass++;
        n_chk++;
        if (oe[i] !== exp_ovr[i])
          $display("FAIL ovr_err lat%0d v=%0d h=%0d got %0b want %0b", lat[i], vv, hh, oe[i], exp_ovr[i]);
        else n_pass++;
      end
    end
    last_h = abort_early ? 641 : 799;
    for (int i = 0; i < 2; i++)
      pending[i] = trig && (last_h < 640 + 3 * (1 + lat[i]) + 1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    v_index = 10'd205;
    for (int x = 0; x < 4; x++) tick(x);
    for (int x = 638; x <= 641; x++) tick(x);
    rst = 1'b1;
    tick(642);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({ds[i], em[i], ls[i], bs[i], bd[i], bm[i], bv[i], oe[i]} !== '0)
        $display("FAIL reset_outputs lat%0d got ds=%0d en=%0b ls=%0d bufs=%h/%h/%h v=%0b o=%0b want all 0",
                 lat[i], ds[i], em[i], ls[i], bs[i], bd[i], bm[i], bv[i], oe[i]);
      else n_pass++;
    end
    tick(643); tick(644);
    rst = 1'b0;
    for (int x = 645; x <= 660; x++) begin
      tick(x);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (em[i] !== 1'b0 || bv[i] !== 1'b0)
          $display("FAIL post_reset lat%0d h=%0d got en=%0b valid=%0b want 0 0", lat[i], x, em[i], bv[i]);
        else n_pass++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) exp_buf[i][k] = '0;
      exp_valid[i] = 1'b0; exp_ovr[i] = 1'b0; pending[i] = 1'b0;
    end
  endtask

  task automatic test_band_entry;
    salt = 16'hA000;
    run_line(199, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({bs[i], bd[i], bm[i], bv[i], ls[i]} !== {32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 1'b1, 5'd0})
        $display("FAIL band_entry lat%0d got %h %h %h v=%0b ls=%0d want A0000000 A0000001 A0000002 v=1 ls=0",
                 lat[i], bs[i], bd[i], bm[i], bv[i], ls[i]);
      else n_pass++;
    end
  endtask

  task automatic test_band_exit;
    salt = 16'($urandom);
    run_line(215, 1'b0);
    n_chk++;
    if (ls[0] !== 5'd16) $display("FAIL line_sel_mid got %0d want 16", ls[0]); else n_pass++;
    salt = 16'($urandom);
    run_line(230, 1'b0);
    n_chk++;
    if (ls[1] !== 5'd31) $display("FAIL line_sel_last got %0d want 31", ls[1]); else n_pass++;
    run_line(231, 1'b0);
    run_line(232, 1'b0);
    n_chk++;
    if (bv[0] !== 1'b0 || bs[0] !== mdata(2'd0, 5'd31, salt))
      $display("FAIL band_exit got valid=%0b sec=%h want valid=0 sec=%h", bv[0], bs[0], mdata(2'd0, 5'd31, salt));
    else n_pass++;
  endtask

  task automatic test_outside_band;
    run_line(100, 1'b0);
    run_line(479, 1'b0);
  endtask

  task automatic test_overrun;
    salt = 16'($urandom);
    run_line(210, 1'b0);
    salt = 16'($urandom);
    run_line(210, 1'b1);
    run_line(100, 1'b0);
    run_line(101, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (oe[i] !== 1'b1) $display("FAIL ovr_sticky lat%0d got %0b want 1", lat[i], oe[i]); else n_pass++;
    end
    salt = 16'($urandom);
    run_line(212, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      int vv;
      vv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 524) : $urandom_range(195, 235);
      salt = 16'($urandom);
      run_line(vv, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; h_index = '0; v_index = '0; salt = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_band_entry;
    test_band_exit;
    test_outside_band;
    test_overrun;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/glyph_fetch_sched.md
Name: glyph_fetch_sched

Overview:
- Sequences the shared glyph memory during horizontal blanking: for the next scan line inside the digit band, fetches one 32-bit glyph row for each of the three time digits.
- Sits between the VGA counters and the mux/mem pair, and drives the digit select, memory enable and line select.
- Stores the three rows in shadow registers and publishes them atomically, so the pixel path reads stable line buffers for the whole visible line.

Parameters:
- H_VIZ, 640, first blanking column; a fetch may start only when h_index == H_VIZ.
- V_TOP, 200, first screen row of the digit band.
- GLYPH_ROWS, 32, number of band rows (one glyph row per screen row).
- MEM_LAT, 1, cycles from an en_mem pulse to valid line_data (range 1..3).

Ports:
- clk_fs  in  1  25 MHz pixel clock.
- rst_fs  in  1  synchronous reset, active-high.
- h_index  in  10  horizontal pixel counter from vga.
- v_index  in  10  vertical line counter from vga.
- line_data  in  32  glyph row returned by mem.
- digit_sel  out  2  mux select: 0=sec, 1=dec, 2=min; 3 is never driven.
- en_mem  out  1  single-cycle memory read strobe.
- line_sel  out  5  glyph row index = target_row - V_TOP.
- buf_sec  out  32  published sec glyph row.
- buf_dec  out  32  published dec glyph row.
- buf_min  out  32  published min glyph row.
- buf_valid  out  1  high when the published buffers belong to the current line.
- ovr_err  out  1  sticky overrun flag.

Behaviour:
- Reset (rst_fs high at a clock edge):
  - State goes to IDLE.
  - digit_sel=0, en_mem=0, line_sel=0.
  - All shadow and buf_* registers are 0.
  - buf_valid=0, ovr_err=0.
  - Reset asserted mid-fetch aborts the fetch immediately. No publish happens.
- Target row: target = v_index + 1, computed 10 bits wide. The row is in band when V_TOP <= target < V_TOP+GLYPH_ROWS. Overflow is impossible because v_index < 525.
- Trigger: in IDLE, when h_index == H_VIZ and target is in band:
  - latch line_sel = target - V_TOP (low 5 bits);
  - set digit index k=0;
  - go to REQ.
  - Otherwise stay in IDLE.
- FSM states: IDLE, REQ, WAIT, CAP, PUB.
- REQ, one cycle:
  - en_mem=1, digit_sel=k (k=0 sec, 1 dec, 2 min).
  - Go to WAIT if MEM_LAT > 1; otherwise go to CAP.
- WAIT:
  - en_mem=0, digit_sel held.
  - Stays for MEM_LAT-1 cycles, counted by a 2-bit counter; then go to CAP.
- CAP, one cycle:
  - Shadow[k] <= line_data. This cycle is exactly MEM_LAT cycles after the REQ cycle.
  - If k==2, go to PUB; else k<=k+1 and go to REQ.
- PUB, one cycle:
  - buf_sec/buf_dec/buf_min <= shadows, all in the same cycle; buf_valid <= 1.
  - Go to IDLE.
- Fetch length is 3*(1+MEM_LAT)+1 cycles: 7 cycles at MEM_LAT=1, finishing well inside the 160-column blanking window.
- en_mem is high only in REQ. It is never high in two consecutive cycles.
- buf_valid clear:
  - At h_index == 0 when v_index is outside the band, buf_valid <= 0; buf_* values are held.
  - On the band's last row, no fetch is triggered, so buf_valid drops at the start of the next line.
- Overrun: if h_index == 0 while state != IDLE:
  - abort to IDLE;
  - ovr_err <= 1 (sticky until reset);
  - buf_valid <= 0;
  - no publish; shadows are left partial.
  - Overrun takes priority over every FSM transition in that cycle.
- Simultaneous events:
  - A trigger condition while not in IDLE is ignored.
  - An overrun abort in the same cycle as a PUB means the abort wins.
  - buf_valid clear and PUB cannot coincide, because PUB never occurs at h_index == 0 without an overrun.
- line_sel is stable from REQ of digit 0 through PUB. It holds its value while in IDLE.

Test Plan:
- Reset: assert rst_fs for 3 cycles mid-frame -> all outputs 0 and state IDLE on the first edge; a fetch in progress produces no en_mem afterwards.
- Band entry: v_index=199, h_index ramps through 640, mem model returns 32'hA000_000s, where s = digit_sel -> line_sel=0; en_mem at h=640, 642, 644 with digit_sel 0, 1, 2; at h=646 buf_sec=A0000000, buf_dec=A0000001, buf_min=A0000002 and buf_valid=1.
- Band middle and exit: v_index=215 -> line_sel=16. v_index=230 -> line_sel=31. At v_index=231 no en_mem occurs; at v_index=232, h=0 -> buf_valid=0 with buffer values held.
- Latency: rebuild with MEM_LAT=3 and a 3-cycle memory model -> REQ cycles at h=640, 644, 648; PUB at h=652; captured data correct; no spurious en_mem.
- Overrun: force h_index from 641 directly to 0 mid-fetch -> return to IDLE, ovr_err=1 and stays 1 over 2 further lines, buf_valid=0, buffers unchanged; the next in-band line fetches normally.
- Outside band: v_index=100 and 479 through blanking -> en_mem never asserted, buf_valid=0, digit_sel never 3.
